// File: rtl/img_pkg.sv
// Shared frame-buffer geometry, pixel type and arbiter enums for the write-side
// blocks.
package img_pkg;

  localparam int N_COLS       = 320;
  localparam int N_ROWS       = 240;
  localparam int FRAME_PIXELS = N_COLS * N_ROWS;
  localparam int ADDR_W       = 17;
  localparam int DATA_W       = 12;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CAP  = 2'b01,
    OWN_CONV = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    CONV = 2'd2
  } arb_state_e;

  function automatic owner_e owner_of(arb_state_e s);
    case (s)
      CAP:     return OWN_CAP;
      CONV:    return OWN_CONV;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_write_arbiter_if.sv
// Requester-side and frame-buffer-side signals of the write arbiter.
// slave = arbiter, master = requesters / buffer model.
interface frame_write_arbiter_if #(
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int DATA_W = img_pkg::DATA_W
);

  logic              cap_en;
  logic              cap_sof;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              conv_req;
  logic              conv_valid;
  logic [DATA_W-1:0] conv_data;
  logic              conv_ready;
  logic              wren;
  logic [ADDR_W-1:0] wraddress;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        owner;
  logic              frame_done;
  logic              cap_err;

  modport slave (
    input  cap_en, cap_sof, cap_valid, cap_data,
    input  conv_req, conv_valid, conv_data,
    output conv_ready, wren, wraddress, data_out, owner, frame_done, cap_err
  );

  modport master (
    output cap_en, cap_sof, cap_valid, cap_data,
    output conv_req, conv_valid, conv_data,
    input  conv_ready, wren, wraddress, data_out, owner, frame_done, cap_err
  );

endinterface

// File: rtl/frame_addr_counter.sv
// Linear pixel address counter shared by capture and convolution frames.
// Saturates at the last pixel; clear with increment loads 1 (pixel 0 written now).
module frame_addr_counter #(
  parameter int ADDR_W       = img_pkg::ADDR_W,
  parameter int FRAME_PIXELS = img_pkg::FRAME_PIXELS
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              increment,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  assign last = (count == ADDR_W'(FRAME_PIXELS - 1));

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= increment ? ADDR_W'(1) : '0;
    end else if (increment && !last) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// Frame-granular arbiter for the single frame-buffer write port: capture vs
// convolution writeback, registered write strobe/address/data.
module frame_write_arbiter #(
  parameter int N_COLS = img_pkg::N_COLS,
  parameter int N_ROWS = img_pkg::N_ROWS,
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int DATA_W = img_pkg::DATA_W
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  frame_write_arbiter_if.slave  bus
);

  import img_pkg::*;

  localparam int FRAME_LEN = N_COLS * N_ROWS;

  arb_state_e        state;
  arb_state_e        state_nxt;

  logic              cnt_clear;
  logic              cnt_inc;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt;

  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              done_p0;
  logic              err_set;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic              done_p1;
  logic              done_p2;
  owner_e            owner_p1;
  logic              ready_p1;
  logic              err_p1;
  // Set once a capture frame finishes; stray capture pixels in IDLE then count as overrun.
  logic              cap_tail;

  frame_addr_counter #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FRAME_LEN)
  ) u_cnt (
    .wr_clk    (wr_clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .increment (cnt_inc),
    .count     (cnt),
    .last      (cnt_last)
  );

  always_ff @(posedge wr_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.cap_en && bus.cap_sof && bus.cap_valid) state_nxt = CAP;
        else if (bus.conv_req)                          state_nxt = CONV;
      end
      CAP:  if (bus.cap_valid && !bus.cap_sof && cnt_last) state_nxt = IDLE;
      CONV: if (bus.conv_valid && ready_p1 && cnt_last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vld_p0    = 1'b0;
    addr_p0   = cnt;
    data_p0   = bus.cap_data;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    done_p0   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (bus.cap_en && bus.cap_sof && bus.cap_valid) begin
          vld_p0  = 1'b1;
          addr_p0 = '0;
          cnt_inc = 1'b1;
        end else if (cap_tail && bus.cap_valid && !bus.cap_sof) begin
          err_set = 1'b1;
        end
      end
      CAP: begin
        if (bus.cap_valid) begin
          vld_p0 = 1'b1;
          if (bus.cap_sof) begin
            // Early SOF: resynchronise on this pixel as the new pixel 0.
            addr_p0   = '0;
            cnt_clear = 1'b1;
            cnt_inc   = 1'b1;
            err_set   = 1'b1;
          end else if (cnt_last) begin
            cnt_clear = 1'b1;
            done_p0   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      CONV: begin
        data_p0 = bus.conv_data;
        if (bus.conv_valid && ready_p1) begin
          vld_p0 = 1'b1;
          if (cnt_last) begin
            cnt_clear = 1'b1;
            done_p0   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // p0 -> p1: registered write port, owner/ready and error flags
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
      owner_p1 <= OWN_NONE;
      ready_p1 <= 1'b0;
      done_p1  <= 1'b0;
      err_p1   <= 1'b0;
      cap_tail <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      owner_p1 <= owner_of(state_nxt);
      ready_p1 <= (state_nxt == CONV);
      done_p1  <= done_p0;
      if (err_set) err_p1 <= 1'b1;
      if (state == CAP && done_p0)                 cap_tail <= 1'b1;
      else if (state == IDLE && state_nxt != IDLE) cap_tail <= 1'b0;
    end
  end

  // p1 -> p2: frame_done trails the final write strobe by one cycle
  always_ff @(posedge wr_clk) begin
    if (!rst_n) done_p2 <= 1'b0;
    else        done_p2 <= done_p1;
  end

  assign bus.wren       = vld_p1;
  assign bus.wraddress  = addr_p1;
  assign bus.data_out   = data_p1;
  assign bus.owner      = owner_p1;
  assign bus.conv_ready = ready_p1;
  assign bus.frame_done = done_p2;
  assign bus.cap_err    = err_p1;

endmodule
